tensor_mac_core: RTL and testbench

TENSOR_MAC_CORE -- requirements
Module: tensor_mac_core

---
 rtl/tensor_mac_core.sv | 135 +++++++++++++
 tb/tb_tensor_mac_core.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tensor_mac_core.sv
// tensor_mac_core
// Assembles 8-byte words from a byte stream, alternates them into a 4x4
// matrix operand pair (A latched from odd words, B = latest word), multiplies
// the two 4x4 matrices of unsigned 4-bit elements mod 16 and accumulates the
// product lane-wise (mod 16 per 4-bit lane) into acc_out.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   Datos_in     input byte, stable for >= 3 cycles after Ena_write rises
//   Ena_write    byte-write strobe (rising edge only)
//   enable_accu  accumulate strobe (rising edge only)
//   clear        synchronous accumulator clear, priority over accumulate
//   acc_out      64-bit accumulator (16 lanes of 4 bits)
//   word_done    one-cycle pulse after the 8th byte of a word is taken
module tensor_mac_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  Datos_in,
  input  logic        Ena_write,
  input  logic        enable_accu,
  input  logic        clear,
  output logic [63:0] acc_out,
  output logic        word_done
);

  localparam int unsigned NUM_BYTES = 8;
  localparam int unsigned DIM       = 4;
  localparam int unsigned ELEM_W    = 4;
  localparam int unsigned SUM_W     = 10;

  logic        wr_d1, wr_d2, ac_d1, ac_d2;
  logic        wr_pulse, ac_pulse;
  logic [2:0]  byte_cnt;
  logic [63:0] hold_reg;
  logic [63:0] word_reg;
  logic [63:0] a_reg;
  logic        sel;
  logic [63:0] p_reg;
  logic [63:0] p_next;
  logic [SUM_W-1:0] mac_sum;

  // Two-flop strobe synchronizers; pulse on rising edge only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_d1 <= 1'b0;
      wr_d2 <= 1'b0;
      ac_d1 <= 1'b0;
      ac_d2 <= 1'b0;
    end else begin
      wr_d1 <= Ena_write;
      wr_d2 <= wr_d1;
      ac_d1 <= enable_accu;
      ac_d2 <= ac_d1;
    end
  end

  assign wr_pulse = wr_d1 & ~wr_d2;
  assign ac_pulse = ac_d1 & ~ac_d2;

  // Byte assembler: lane n takes the n-th byte; the 8th byte publishes the word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt  <= 3'd0;
      hold_reg  <= 64'h0;
      word_reg  <= 64'h0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (wr_pulse) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (byte_cnt == 3'(i)) hold_reg[8*i +: 8] <= Datos_in;
        end
        byte_cnt <= byte_cnt + 3'd1;
        if (byte_cnt == 3'd7) begin
          // The last lane comes straight from the input, not the holding register
          word_reg  <= {Datos_in, hold_reg[55:0]};
          word_done <= 1'b1;
        end
      end
    end
  end

  // Operand sequencing: odd words load A, even words stay in word_reg as B
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg <= 64'h0;
      sel   <= 1'b0;
    end else if (word_done) begin
      if (!sel) begin
        a_reg <= word_reg;
        sel   <= 1'b1;
      end else begin
        sel   <= 1'b0;
      end
    end
  end

  // 4x4 matrix product, each element truncated to 4 bits
  always_comb begin
    p_next  = 64'h0;
    mac_sum = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        mac_sum = '0;
        for (int k = 0; k < DIM; k++) begin
          mac_sum = mac_sum
                  + SUM_W'(a_reg[(DIM*r + k)*ELEM_W +: ELEM_W])
                  * SUM_W'(word_reg[(DIM*k + c)*ELEM_W +: ELEM_W]);
        end
        p_next[(DIM*r + c)*ELEM_W +: ELEM_W] = mac_sum[ELEM_W-1:0];
      end
    end
  end

  // Product register (one cycle latency from A/B)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) p_reg <= 64'h0;
    else      p_reg <= p_next;
  end

  // Accumulator: clear wins, else lane-wise mod-16 add on accumulate pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_out <= 64'h0;
    end else if (clear) begin
      acc_out <= 64'h0;
    end else if (ac_pulse) begin
      for (int i = 0; i < 16; i++) begin
        acc_out[ELEM_W*i +: ELEM_W] <= acc_out[ELEM_W*i +: ELEM_W] + p_reg[ELEM_W*i +: ELEM_W];
      end
    end
  end

endmodule

// File: tb/tb_tensor_mac_core.sv
// tb_tensor_mac_core
// Directed bench for tensor_mac_core: expected accumulator values are queued
// when an accumulate is issued and popped when the result is sampled.
module tb_tensor_mac_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  Datos_in;
  logic        Ena_write;
  logic        enable_accu;
  logic        clear;
  logic [63:0] acc_out;
  logic        word_done;

  int total = 0;
  int bad = 0;
  int wd_count = 0;
  int wd_base;
  logic [63:0] exp_q[$];

  localparam logic [63:0] B_WORD = 64'h0123456789ABCDEF;

  tensor_mac_core dut (
    .clk         (clk),
    .rst         (rst),
    .Datos_in    (Datos_in),
    .Ena_write   (Ena_write),
    .enable_accu (enable_accu),
    .clear       (clear),
    .acc_out     (acc_out),
    .word_done   (word_done)
  );

  always #5 clk = ~clk;

  // Count word_done pulses away from the active edge
  always @(negedge clk) begin
    if (word_done === 1'b1) wd_count++;
  end

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    Datos_in  = b;
    Ena_write = 1'b1;
    repeat (4) @(negedge clk);
    Ena_write = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic write_word(input logic [63:0] w);
    logic [63:0] tmp;
    tmp = w;
    for (int i = 0; i < 8; i++) write_byte(tmp[8*i +: 8]);
  endtask

  task automatic accumulate(input logic [63:0] exp);
    @(negedge clk);
    enable_accu = 1'b1;
    exp_q.push_back(exp);
    repeat (4) @(negedge clk);
    enable_accu = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_acc(input string tag);
    logic [63:0] e;
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check64(tag, acc_out, e);
    end
  endtask

  initial begin
    rst         = 1'b0;
    Datos_in    = 8'h00;
    Ena_write   = 1'b0;
    enable_accu = 1'b0;
    clear       = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check64("reset_acc", acc_out, 64'h0);
    check_int("reset_word_done", int'(word_done), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Identity A, then B
    write_word(64'h1000_0100_0010_0001);
    #1;
    check_int("word_a_done", wd_count, 1);
    write_word(B_WORD);
    #1;
    check_int("word_b_done", wd_count, 2);
    repeat (3) @(negedge clk);
    accumulate(B_WORD);
    check_acc("identity_mul");

    // Second accumulate exercises per-lane wrap
    accumulate(64'h02468ACE02468ACE);
    check_acc("lane_wrap");

    // Clear held through an accumulate pulse
    @(negedge clk);
    clear = 1'b1;
    accumulate(64'h0);
    check_acc("clear_priority");
    @(negedge clk);
    clear = 1'b0;
    accumulate(B_WORD);
    check_acc("after_clear");

    // Level-held Ena_write must take exactly one byte
    @(negedge clk);
    Datos_in  = 8'h22;
    Ena_write = 1'b1;
    repeat (20) @(negedge clk);
    Ena_write = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_int("edge_only_no_word", wd_count, 2);
    for (int i = 0; i < 6; i++) write_byte(8'h22);
    #1;
    check_int("seven_bytes_no_word", wd_count, 2);
    write_byte(8'h22);
    #1;
    check_int("word3_done", wd_count, 3);

    // Fourth word becomes B; third replaced A
    write_word(64'h1111111111111111);
    #1;
    check_int("word4_done", wd_count, 4);
    @(negedge clk);
    clear = 1'b1;
    exp_q.push_back(64'h0);
    @(negedge clk);
    clear = 1'b0;
    check_acc("clear_alone");
    repeat (2) @(negedge clk);
    accumulate(64'h8888888888888888);
    check_acc("alternation");

    // Reset mid-word discards the partial bytes
    write_byte(8'h55);
    write_byte(8'h66);
    write_byte(8'h77);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check64("midreset_acc", acc_out, 64'h0);
    check_int("midreset_word_done", int'(word_done), 0);
    @(negedge clk);
    rst = 1'b1;
    wd_base = wd_count;
    for (int i = 0; i < 7; i++) write_byte(8'h00);
    #1;
    check_int("fresh_word_partial", wd_count - wd_base, 0);
    write_byte(8'h00);
    #1;
    check_int("fresh_word_done", wd_count - wd_base, 1);
    // Zero A word completed; next word is B, so A*B = 0
    write_word(B_WORD);
    #1;
    check_int("fresh_b_done", wd_count - wd_base, 2);
    repeat (3) @(negedge clk);
    accumulate(64'h0);
    check_acc("zero_a_product");
    // Restore identity A with new pair and confirm product
    write_word(64'h1000_0100_0010_0001);
    write_word(64'hFEDCBA9876543210);
    repeat (3) @(negedge clk);
    accumulate(64'hFEDCBA9876543210);
    check_acc("post_reset_identity");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
